// File: rtl/hs_fifo_pkg.sv
// Shared constants and helpers for the req/ack elastic buffer and its bench models.
package hs_fifo_pkg;

  localparam int CNT_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// A responder may only ack while the requester is holding req high.
`ifndef HS_PROTO_ASSERT
`define HS_PROTO_ASSERT(CLK, RST, REQ, ACK, NAME) \
  NAME: assert property (@(posedge CLK) disable iff (RST) (ACK) |-> (REQ));
`endif

// File: rtl/hs_fifo_if.sv
// Upstream (requester side) and downstream (responder side) token handshake of hs_fifo.
interface hs_fifo_if #(
  parameter int data_width = 32
);
  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout;

  modport slave  (output req_l, input  ack_l, input  din,
                  input  req_r, output ack_r, output dout);
  modport master (input  req_l, output ack_l, output din,
                  output req_r, input  ack_r, input  dout);
endinterface

// File: rtl/hs_fifo_mem.sv
// Token storage: one synchronous write port, one asynchronous read port, no reset.
module hs_fifo_mem
  import hs_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(depth)-1:0]   waddr,
  input  logic [data_width-1:0]     wdata,
  input  logic [clog2(depth)-1:0]   raddr,
  output logic [data_width-1:0]     rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo.sv
// Multi-entry req/ack elastic buffer: requests tokens upstream, serves them downstream in order.
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  hs_fifo_if.slave                hs,
  output logic [clog2(depth):0]   occupancy,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        count_in,
  output logic [CNT_W-1:0]        count_out
);

  localparam int addr_width = clog2(depth);
  localparam logic [addr_width:0]   DEPTH_V = (addr_width+1)'(depth);
  localparam logic [addr_width:0]   OCC_ONE = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);

  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [data_width-1:0] rdata;
  logic [addr_width:0]   occ_nxt;
  logic                  push, pop;

  // An ack that arrives without an outstanding request is dropped.
  assign push = hs.ack_l & hs.req_l;
  // No bypass: only tokens already stored before this edge can leave.
  assign pop  = hs.req_r & ~hs.ack_r & ~empty;

  always_comb begin
    occ_nxt = occupancy;
    case ({push, pop})
      2'b10:   occ_nxt = occupancy + OCC_ONE;
      2'b01:   occ_nxt = occupancy - OCC_ONE;
      default: occ_nxt = occupancy;
    endcase
  end

  hs_fifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (hs.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs.req_l  <= 1'b0;
      wr_ptr    <= '0;
      count_in  <= '0;
    end else begin
      if (hs.ack_l) begin
        hs.req_l <= 1'b0;
      end else if (!hs.req_l && occupancy < DEPTH_V) begin
        hs.req_l <= 1'b1;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        count_in <= count_in + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs.ack_r  <= 1'b0;
      hs.dout   <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      hs.ack_r <= pop;
      if (pop) begin
        hs.dout   <= rdata;
        rd_ptr    <= rd_ptr + PTR_ONE;
        count_out <= count_out + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      occupancy <= occ_nxt;
      full      <= (occ_nxt == DEPTH_V);
      empty     <= (occ_nxt == '0);
    end
  end

  `HS_PROTO_ASSERT(clk, rst, hs.req_l, hs.ack_l, a_ack_l_needs_req)

endmodule

// File: tb/tb_hs_fifo.sv
// Scoreboard bench for hs_fifo: directed fill/drain/reset cases plus streamed token runs.
module tb_hs_fifo;
  import hs_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [clog2(DEPTH):0] occupancy;
  logic full, empty;
  logic [CNT_W-1:0] count_in, count_out;

  hs_fifo_if #(.data_width(DW)) hs ();

  hs_fifo #(.data_width(DW), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .count_in  (count_in),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int max_occ = 0;
  bit run_mon = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered token must match the oldest token sent in.
  always @(negedge clk) begin
    if (run_mon && !rst) begin
      if (hs.ack_r) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout: got %0d expected no token at %0t", hs.dout, $time);
        end else begin
          chk("dout", hs.dout, exp_q.pop_front());
        end
      end
      chk("occ_balance", count_in - count_out, 32'(occupancy));
      chk("occ_le_depth", 32'(occupancy <= DEPTH), 32'd1);
      chk("full_flag", 32'(full), 32'(occupancy == DEPTH));
      chk("empty_flag", 32'(empty), 32'(occupancy == 0));
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_req_l"}, 32'(hs.req_l), 32'd0);
    chk({tag, "_ack_r"}, 32'(hs.ack_r), 32'd0);
    chk({tag, "_dout"}, hs.dout, 32'd0);
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_cnt_in"}, count_in, 32'd0);
    chk({tag, "_cnt_out"}, count_out, 32'd0);
  endtask

  task automatic wait_req_l();
    int c = 0;
    @(negedge clk);
    while (!hs.req_l && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("req_l_timeout", 32'(hs.req_l), 32'd1);
  endtask

  task automatic send_token(input logic [DW-1:0] v);
    wait_req_l();
    @(posedge clk); #1;
    hs.ack_l = 1'b1;
    hs.din   = v;
    exp_q.push_back(v);
    @(posedge clk); #1;
    hs.ack_l = 1'b0;
  endtask

  // Bench producer (responder) and consumer (requester) with per-cycle stall odds.
  task automatic run_stream(input int n, input int pfail, input int cfail, input int base);
    int  sent = 0;
    int  cyc  = 0;
    int  rx0  = rx_cnt;
    bit  nack, nreq;
    while ((rx_cnt - rx0) < n && cyc < 60000) begin
      @(negedge clk);
      nack = hs.req_l && !hs.ack_l && (sent < n) && ($urandom_range(99) >= pfail);
      if (hs.req_r && hs.ack_r) nreq = 1'b0;
      else if (!hs.req_r)       nreq = ($urandom_range(99) >= cfail);
      else                      nreq = 1'b1;
      @(posedge clk); #1;
      hs.ack_l = nack;
      if (nack) begin
        hs.din = DW'(base + sent);
        exp_q.push_back(DW'(base + sent));
        sent++;
      end
      hs.req_r = nreq;
      cyc++;
    end
    chk("stream_received", 32'(rx_cnt - rx0), 32'(n));
    @(posedge clk); #1;
    hs.ack_l = 1'b0;
    hs.req_r = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pulses, b2b;
    bit prev;
    rst = 1'b1;
    hs.ack_l = 1'b0;
    hs.din   = '0;
    hs.req_r = 1'b0;
    #1;
    reset_vals("init");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_l", 32'(hs.req_l), 32'd1);
    chk("post_rst_empty", 32'(empty), 32'd1);
    run_mon = 1'b1;

    // Fill with no downstream demand.
    for (int i = 0; i < 4; i++) begin
      send_token(DW'(10 + i));
      @(negedge clk);
      chk("fill_occ", 32'(occupancy), 32'(i + 1));
      chk("fill_full", 32'(full), 32'(i == 3));
    end
    repeat (3) @(negedge clk);
    chk("fill_req_l_low", 32'(hs.req_l), 32'd0);
    chk("fill_count_in", count_in, 32'd4);

    // Drain with req_r held high: one pop every other cycle.
    @(posedge clk); #1;
    hs.req_r = 1'b1;
    pulses = 0;
    b2b = 0;
    prev = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (hs.ack_r) pulses++;
      if (hs.ack_r && prev) b2b++;
      prev = hs.ack_r;
    end
    chk("drain_pulses", 32'(pulses), 32'd4);
    chk("drain_back_to_back", 32'(b2b), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ack_r_idle", 32'(hs.ack_r), 32'd0);
    chk("drain_count_out", count_out, 32'd4);
    @(posedge clk); #1;
    hs.req_r = 1'b0;

    // Push and pop on the same edge at occupancy 1.
    send_token(DW'(20));
    @(negedge clk);
    chk("simul_pre_occ", 32'(occupancy), 32'd1);
    wait_req_l();
    @(posedge clk); #1;
    hs.ack_l = 1'b1;
    hs.din   = DW'(21);
    exp_q.push_back(DW'(21));
    hs.req_r = 1'b1;
    @(posedge clk); #1;
    hs.ack_l = 1'b0;
    hs.req_r = 1'b0;
    @(negedge clk);
    chk("simul_occ", 32'(occupancy), 32'd1);
    chk("simul_full", 32'(full), 32'd0);
    chk("simul_empty", 32'(empty), 32'd0);
    chk("simul_ack_r", 32'(hs.ack_r), 32'd1);
    chk("simul_count_in", count_in, 32'd6);
    chk("simul_count_out", count_out, 32'd5);

    // Asynchronous reset mid-cycle with a token still stored.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    reset_vals("async");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_req_l", 32'(hs.req_l), 32'd1);
    chk("rel_empty", 32'(empty), 32'd1);

    max_occ = 0;
    run_stream(5000, 0, 0, 0);
    chk("stream_max_occ", 32'(max_occ <= 2), 32'd1);

    run_stream(5000, 30, 50, 10000);
    chk("final_count_in", count_in, 32'd10000);
    chk("final_count_out", count_out, 32'd10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
